// File: rtl/ucode_sequencer.sv
// Multiply microcode sequencer: walks the microcode ROM for one multiply
// instruction, runs the hardware loop counter, substitutes the real rd/rs
// into register hole fields and hands expanded micro-ops to decode.
module ucode_sequencer #(
    parameter int UPC_W       = 5,
    parameter int ENTRY_MUL   = 0,
    parameter int ENTRY_MULI  = 8,
    parameter int ENTRY_SMUL  = 16,
    parameter int ENTRY_SMULI = 24,
    parameter int MAX_STEPS   = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       opcode,
    input  logic [3:0]       rd,
    input  logic [3:0]       rs,
    input  logic [15:0]      imm,
    input  logic             stall,
    input  logic             flush,
    output logic [UPC_W-1:0] rom_addr,
    input  logic [31:0]      rom_data,
    output logic [31:0]      uinst,
    output logic             uinst_valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam logic [6:0] OP_MUL   = 7'b0010000;
    localparam logic [6:0] OP_MULI  = 7'b0011000;
    localparam logic [6:0] OP_SMUL  = 7'b0110000;
    localparam logic [6:0] OP_SMULI = 7'b0111000;

    localparam logic [UPC_W-1:0] ENTRY_MUL_A   = UPC_W'(ENTRY_MUL);
    localparam logic [UPC_W-1:0] ENTRY_MULI_A  = UPC_W'(ENTRY_MULI);
    localparam logic [UPC_W-1:0] ENTRY_SMUL_A  = UPC_W'(ENTRY_SMUL);
    localparam logic [UPC_W-1:0] ENTRY_SMULI_A = UPC_W'(ENTRY_SMULI);
    localparam logic [7:0]       STEP_LIMIT    = 8'(MAX_STEPS);

    localparam logic [3:0]  END_TAG  = 4'b1101;
    localparam logic [10:0] LOOP_TAG = 11'b11000010000;
    localparam logic [3:0]  REG_HOLE = 4'hF;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state, state_nx;
    logic [UPC_W-1:0] upc, upc_nx;
    logic [15:0]      cnt, cnt_nx;
    logic [7:0]       steps, steps_nx;
    logic             done_nx;
    logic             err_nx;
    logic             latch_regs;
    logic [3:0]       rd_lat;
    logic [3:0]       rs_lat;

    logic             op_ok;
    logic [UPC_W-1:0] entry;
    logic             is_end;
    logic             is_loop;
    logic             wd_trip;
    logic [UPC_W-1:0] loop_off;

    // Classify the current ROM word and the watchdog condition.
    always_comb begin
        is_end   = (rom_data[31:28] == END_TAG);
        is_loop  = (rom_data[31:21] == LOOP_TAG);
        wd_trip  = (steps == STEP_LIMIT) && !is_end;
        loop_off = rom_data[UPC_W-1:0];
    end

    // Map the multiply opcode to its ROM entry point; anything else is rejected.
    always_comb begin
        op_ok = 1'b1;
        entry = '0;
        case (opcode)
            OP_MUL:   entry = ENTRY_MUL_A;
            OP_MULI:  entry = ENTRY_MULI_A;
            OP_SMUL:  entry = ENTRY_SMUL_A;
            OP_SMULI: entry = ENTRY_SMULI_A;
            default:  op_ok = 1'b0;
        endcase
    end

    // Next-state and issue logic; flush overrides everything but reset.
    always_comb begin
        state_nx    = state;
        upc_nx      = upc;
        cnt_nx      = cnt;
        steps_nx    = steps;
        done_nx     = 1'b0;
        err_nx      = err;
        latch_regs  = 1'b0;
        uinst_valid = 1'b0;

        if (flush) begin
            state_nx = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && op_ok) begin
                        upc_nx     = entry;
                        cnt_nx     = imm;
                        steps_nx   = '0;
                        err_nx     = 1'b0;
                        latch_regs = 1'b1;
                        state_nx   = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        steps_nx = steps + 8'd1;
                        if (is_end) begin
                            // END wins over the watchdog: a sequence finishing on
                            // its last permitted step is a clean finish.
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                        end else if (wd_trip) begin
                            state_nx = S_IDLE;
                            err_nx   = 1'b1;
                            done_nx  = 1'b1;
                        end else if (is_loop) begin
                            // Counts of 0 and 1 both fall through after one body pass.
                            if (cnt > 16'd1) begin
                                cnt_nx = cnt - 16'd1;
                                upc_nx = upc - loop_off;
                            end else begin
                                cnt_nx = '0;
                                upc_nx = upc + 1'b1;
                            end
                        end else begin
                            uinst_valid = 1'b1;
                            upc_nx      = upc + 1'b1;
                        end
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Register-hole substitution; outside RUN the ROM word passes straight through.
    always_comb begin
        uinst = rom_data;
        if (state == S_RUN) begin
            if (rom_data[24:21] == REG_HOLE) uinst[24:21] = rd_lat;
            if (rom_data[20:17] == REG_HOLE) uinst[20:17] = rs_lat;
        end
    end

    // Sequencer control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            upc   <= '0;
            cnt   <= '0;
            steps <= '0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            upc   <= upc_nx;
            cnt   <= cnt_nx;
            steps <= steps_nx;
            done  <= done_nx;
            err   <= err_nx;
        end
    end

    // Register operands captured with an accepted start.
    always_ff @(posedge clk) begin
        if (latch_regs) begin
            rd_lat <= rd;
            rs_lat <= rs;
        end
    end

    assign rom_addr = upc;
    assign busy     = (state == S_RUN);

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer with a small behavioural microcode ROM.
module tb_ucode_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        stall;
    logic        flush;
    logic [4:0]  rom_addr;
    logic [31:0] rom_data;
    logic [31:0] uinst;
    logic        uinst_valid;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] rom [32];

    int vectors;
    int miscompares;

    localparam logic [6:0]  OP_MUL   = 7'b0010000;
    localparam logic [6:0]  OP_MULI  = 7'b0011000;
    localparam logic [6:0]  OP_SMUL  = 7'b0110000;
    localparam logic [31:0] W_END    = 32'hD000_0000;
    localparam logic [31:0] W_BODY   = 32'h3000_0042;

    ucode_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .rd(rd), .rs(rs),
        .imm(imm), .stall(stall), .flush(flush), .rom_addr(rom_addr),
        .rom_data(rom_data), .uinst(uinst), .uinst_valid(uinst_valid),
        .busy(busy), .done(done), .err(err)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [6:0] op, input logic [3:0] r_d,
                            input logic [3:0] r_s, input logic [15:0] im);
        start  = 1'b1;
        opcode = op;
        rd     = r_d;
        rs     = r_s;
        imm    = im;
        step();
        start  = 1'b0;
    endtask

    // Runs the active sequence until busy drops (bounded), optionally stalling.
    task automatic run_seq(input int stall_at, input int stall_len, input logic [31:0] exp_u,
                           output int issues, output int cycles, output int stall_bad,
                           output int bad_u, output logic [15:0] cnt_at_end);
        logic [4:0] frozen;
        issues = 0; cycles = 0; stall_bad = 0; bad_u = 0; frozen = '0; cnt_at_end = 16'hDEAD;
        for (int c = 0; c < 400; c++) begin
            stall = (c >= stall_at) && (c < stall_at + stall_len);
            #1;
            if (!busy) break;
            if (c == stall_at) frozen = rom_addr;
            if (uinst_valid) begin
                issues++;
                if (uinst !== exp_u) bad_u++;
            end
            if (stall && (uinst_valid || rom_addr !== frozen)) stall_bad++;
            if (rom_data[31:28] == 4'hD) cnt_at_end = dut.cnt;
            cycles++;
            step();
        end
        stall = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        vectors++; if (rom_addr !== 5'd0) begin miscompares++; $display("FAIL reset_addr got=%0d want=0", rom_addr); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++; if (uinst_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b want=0", uinst_valid); end
        vectors++; if (done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL reset_done_err got=%b%b want=00", done, err); end
        vectors++; if (uinst !== 32'h11FE_0ABC) begin miscompares++; $display("FAIL reset_passthru got=%h want=11fe0abc", uinst); end
    endtask

    task automatic test_mul_subst();
        do_start(OP_MUL, 4'd3, 4'd5, 16'd0);
        #1;
        vectors++; if (busy !== 1'b1 || rom_addr !== 5'd0) begin miscompares++; $display("FAIL mul_c1_busy_addr got=%b/%0d want=1/0", busy, rom_addr); end
        vectors++; if (uinst_valid !== 1'b1 || uinst !== 32'h106A_0ABC) begin miscompares++; $display("FAIL mul_c1_uinst got=%b/%h want=1/106a0abc", uinst_valid, uinst); end
        step();
        vectors++; if (uinst_valid !== 1'b1 || uinst !== 32'h2060_0001) begin miscompares++; $display("FAIL mul_c2_uinst got=%b/%h want=1/20600001", uinst_valid, uinst); end
        step();
        vectors++; if (rom_addr !== 5'd2 || uinst_valid !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL mul_c3_end got=%0d/%b/%b/%b want=2/0/1/0", rom_addr, uinst_valid, busy, done); end
        step();
        vectors++; if (busy !== 1'b0 || done !== 1'b1) begin miscompares++; $display("FAIL mul_done got=%b/%b want=0/1", busy, done); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL mul_done_pulse got=%b want=0", done); end
    endtask

    task automatic test_loop(input logic [15:0] im, input int exp_issues, input int exp_cycles);
        int is, cy, sb, bu;
        logic [15:0] ce;
        do_start(OP_MULI, 4'd1, 4'd2, im);
        run_seq(-1, 0, W_BODY, is, cy, sb, bu, ce);
        vectors++; if (is !== exp_issues) begin miscompares++; $display("FAIL loop_issues imm=%0d got=%0d want=%0d", im, is, exp_issues); end
        vectors++; if (cy !== exp_cycles) begin miscompares++; $display("FAIL loop_cycles imm=%0d got=%0d want=%0d", im, cy, exp_cycles); end
        vectors++; if (bu !== 0 || ce !== 16'd0) begin miscompares++; $display("FAIL loop_uinst_cnt imm=%0d got=%0d/%h want=0/0000", im, bu, ce); end
        vectors++; if (done !== 1'b1 || err !== 1'b0) begin miscompares++; $display("FAIL loop_done imm=%0d got=%b/%b want=1/0", im, done, err); end
        step();
    endtask

    task automatic test_stall();
        int is, cy, sb, bu;
        logic [15:0] ce;
        do_start(OP_MULI, 4'd1, 4'd2, 16'd4);
        run_seq(2, 3, W_BODY, is, cy, sb, bu, ce);
        vectors++; if (sb !== 0) begin miscompares++; $display("FAIL stall_frozen got=%0d want=0", sb); end
        vectors++; if (is !== 4 || bu !== 0) begin miscompares++; $display("FAIL stall_issues got=%0d/%0d want=4/0", is, bu); end
        vectors++; if (cy !== 12) begin miscompares++; $display("FAIL stall_cycles got=%0d want=12", cy); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL stall_done got=%b want=1", done); end
        step();
    endtask

    task automatic test_ignored();
        do_start(7'b0010001, 4'd1, 4'd1, 16'd1);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL bad_opcode_busy got=%b want=0", busy); end
        start = 1'b1; opcode = OP_MUL; flush = 1'b1;
        step();
        start = 1'b0; flush = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL flush_start_idle got=%b/%b want=0/0", busy, done); end
    endtask

    task automatic test_flush_watchdog();
        int is, cy, sb, bu;
        logic [15:0] ce;
        do_start(OP_MULI, 4'd1, 4'd2, 16'd4);
        step(); step();
        flush = 1'b1;
        #1;
        vectors++; if (uinst_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got=%b want=0", uinst_valid); end
        step();
        flush = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL flush_idle got=%b/%b/%b want=0/0/0", busy, done, err); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL flush_nodone got=%b want=0", done); end
        do_start(OP_SMUL, 4'd7, 4'd8, 16'hFFFF);
        vectors++; if (busy !== 1'b1 || rom_addr !== 5'd16) begin miscompares++; $display("FAIL smul_entry got=%b/%0d want=1/16", busy, rom_addr); end
        run_seq(-1, 0, W_BODY, is, cy, sb, bu, ce);
        vectors++; if (cy !== 256 || is !== 0) begin miscompares++; $display("FAIL wd_cycles got=%0d/%0d want=256/0", cy, is); end
        vectors++; if (done !== 1'b1 || err !== 1'b1) begin miscompares++; $display("FAIL wd_abort got=%b/%b want=1/1", done, err); end
        step();
        vectors++; if (done !== 1'b0 || err !== 1'b1) begin miscompares++; $display("FAIL wd_sticky got=%b/%b want=0/1", done, err); end
        do_start(OP_MUL, 4'd3, 4'd5, 16'd0);
        vectors++; if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL err_clear got=%b/%b want=0/1", err, busy); end
        run_seq(-1, 0, 32'h106A_0ABC, is, cy, sb, bu, ce);
        vectors++; if (is !== 2 || cy !== 3) begin miscompares++; $display("FAIL after_wd_seq got=%0d/%0d want=2/3", is, cy); end
        step();
    endtask

    task automatic test_reset_mid_run();
        do_start(OP_MULI, 4'd1, 4'd2, 16'd4);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++; if (busy !== 1'b0 || done !== 1'b0 || rom_addr !== 5'd0) begin miscompares++; $display("FAIL rst_mid got=%b/%b/%0d want=0/0/0", busy, done, rom_addr); end
        step();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rst_mid_nodone got=%b want=0", done); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; start = 1'b0; opcode = '0; rd = '0; rs = '0; imm = '0;
        stall = 1'b0; flush = 1'b0;
        for (int i = 0; i < 32; i++) rom[i] = 32'h0;
        rom[0]  = 32'h11FE_0ABC;
        rom[1]  = 32'h21E0_0001;
        rom[2]  = W_END;
        rom[8]  = W_BODY;
        rom[9]  = 32'hC200_0001;
        rom[10] = W_END;
        rom[16] = 32'hC200_0000;
        rom[17] = W_END;

        test_reset();
        test_mul_subst();
        test_loop(16'd4, 4, 9);
        test_loop(16'd0, 1, 3);
        test_loop(16'd1, 1, 3);
        test_stall();
        test_ignored();
        test_flush_watchdog();
        test_reset_mid_run();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
